// File: rtl/bsg_cover_pkg.sv
// Shared types and constants for the coverage packer.
// Optional feature macro used by the packer: BSG_COVER_PACKER_TRAILER_EN.
package bsg_cover_pkg;

    // Packer FSM states; StTrail is only reachable with the trailer build.
    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StEnd,
        StTrail
    } cover_state_e;

    // Default header field widths (match the packer's default parameters).
    localparam int unsigned DefIdWidth  = 8;
    localparam int unsigned DefElsWidth = 16;
    localparam int unsigned DefLenWidth = 8;

    // Header layout: id sits in the LSBs, len in the MSBs.
    typedef struct packed {
        logic [DefLenWidth-1:0] len;
        logic [DefElsWidth-1:0] els;
        logic [DefIdWidth-1:0]  id;
    } cover_hdr_t;

    // Fill bit replicated across the whole end-of-packet beat.
    localparam logic        EndBeatFill  = 1'b1;
    // Magic tag in the top 16 bits of a trailer beat.
    localparam logic [15:0] TrailerMagic = 16'hC0DE;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_cover_rr_arb.sv
// Round-robin arbiter over the collector header requests.
// The search starts at the channel after the last advanced grant.
module bsg_cover_rr_arb
    import bsg_cover_pkg::*;
#(
    parameter int unsigned num_p = 4,
    localparam int unsigned PtrW = ptr_width(num_p)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [num_p-1:0] reqs_i,
    input  logic            advance_i,
    input  logic [PtrW-1:0] adv_id_i,
    output logic [num_p-1:0] grant_oh_o,
    output logic [PtrW-1:0] grant_id_o,
    output logic            grant_v_o
);

    logic [PtrW-1:0] ptr_q, ptr_d;

    // First requester at or after the pointer, wrapping at num_p.
    always_comb begin
        int unsigned c;
        c          = 0;
        grant_v_o  = 1'b0;
        grant_id_o = '0;
        grant_oh_o = '0;
        for (int unsigned i = 0; i < num_p; i++) begin
            c = 32'(ptr_q) + i;
            if (c >= num_p) begin
                c = c - num_p;
            end
            if (!grant_v_o && reqs_i[c]) begin
                grant_v_o  = 1'b1;
                grant_id_o = PtrW'(c);
            end
        end
        if (grant_v_o) begin
            grant_oh_o[grant_id_o] = 1'b1;
        end
    end

    // Pointer moves past the channel that just completed; held at 0 for one channel.
    always_comb begin
        ptr_d = ptr_q;
        if (num_p > 1 && advance_i) begin
            if (adv_id_i == PtrW'(num_p - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = adv_id_i + PtrW'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bsg_cover_packer.sv
// Packs drains from num_p coverage collectors into framed packets
// (header beat, data beats, closing beat) on one stream, and sequences
// host drain requests across all collectors.
// Optional: define BSG_COVER_PACKER_TRAILER_EN to close every packet with a
// counted trailer beat instead of tagging the last data beat / end beat.
module bsg_cover_packer
    import bsg_cover_pkg::*;
#(
    parameter int unsigned num_p       = 4,
    parameter int unsigned out_width_p = 64,
    parameter int unsigned id_width_p  = 8,
    parameter int unsigned els_width_p = 16,
    parameter int unsigned len_width_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         drain_i,
    output logic [num_p-1:0]             drain_o,
    input  logic [num_p-1:0]             gate_i,
    output logic                         drain_done_o,
    input  logic [num_p-1:0]             id_v_i,
    input  logic [num_p*id_width_p-1:0]  id_i,
    input  logic [num_p*els_width_p-1:0] els_i,
    input  logic [num_p*len_width_p-1:0] len_i,
    output logic [num_p-1:0]             ready_o,
    input  logic [num_p-1:0]             v_i,
    input  logic [num_p-1:0]             last_i,
    input  logic [num_p*out_width_p-1:0] data_i,
    output logic                         v_o,
    output logic                         last_o,
    output logic [out_width_p-1:0]       data_o,
    input  logic                         ready_i
);

    localparam int unsigned PtrW = ptr_width(num_p);
    localparam int unsigned HdrW = id_width_p + els_width_p + len_width_p;

    cover_state_e     state_q, state_d;
    logic [PtrW-1:0]  grant_q, grant_d;
    logic [num_p-1:0] grant_oh_q, grant_oh_d;
    logic [num_p-1:0] pending_q, pending_d;
    logic             active_q, active_d;

`ifdef BSG_COVER_PACKER_TRAILER_EN
    localparam int unsigned CntW = out_width_p / 2;
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    logic [num_p-1:0] arb_oh;
    logic [PtrW-1:0]  arb_id;
    logic             arb_v;
    logic             rr_adv;
    logic             hdr_xfer;

    bsg_cover_rr_arb #(
        .num_p(num_p)
    ) u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .reqs_i    (id_v_i),
        .advance_i (rr_adv),
        .adv_id_i  (grant_q),
        .grant_oh_o(arb_oh),
        .grant_id_o(arb_id),
        .grant_v_o (arb_v)
    );

    // Fields of the currently granted channel.
    logic [id_width_p-1:0]  id_g;
    logic [els_width_p-1:0] els_g;
    logic [len_width_p-1:0] len_g;
    logic [out_width_p-1:0] data_g;
    logic                   v_g, last_g, gate_g;

    assign id_g   = id_i[grant_q*id_width_p +: id_width_p];
    assign els_g  = els_i[grant_q*els_width_p +: els_width_p];
    assign len_g  = len_i[grant_q*len_width_p +: len_width_p];
    assign data_g = data_i[grant_q*out_width_p +: out_width_p];
    assign v_g    = v_i[grant_q];
    assign last_g = last_i[grant_q];
    assign gate_g = gate_i[grant_q];

    assign hdr_xfer = (state_q == StHdr) && ready_i;
    assign drain_o  = pending_q;

    // Packet FSM: next state and the stream/ready outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_adv     = 1'b0;
        v_o        = 1'b0;
        last_o     = 1'b0;
        data_o     = '0;
        ready_o    = '0;
`ifdef BSG_COVER_PACKER_TRAILER_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_v) begin
                    grant_d    = arb_id;
                    grant_oh_d = arb_oh;
                    state_d    = StHdr;
                end
            end
            StHdr: begin
                v_o              = 1'b1;
                data_o[HdrW-1:0] = {len_g, els_g, id_g};
                ready_o          = grant_oh_q & {num_p{ready_i}};
                if (ready_i) begin
                    state_d = StData;
`ifdef BSG_COVER_PACKER_TRAILER_EN
                    cnt_d   = '0;
`endif
                end
            end
            StData: begin
                v_o     = v_g;
                data_o  = data_g;
                ready_o = grant_oh_q & {num_p{ready_i}};
`ifdef BSG_COVER_PACKER_TRAILER_EN
                last_o  = 1'b0;
`else
                last_o  = last_g;
`endif
                if (v_g && ready_i) begin
`ifdef BSG_COVER_PACKER_TRAILER_EN
                    cnt_d = cnt_q + CntW'(1);
`endif
                    if (last_g) begin
                        rr_adv  = 1'b1;
`ifdef BSG_COVER_PACKER_TRAILER_EN
                        state_d = StTrail;
`else
                        state_d = StIdle;
`endif
                    end
                end else if (!gate_g && !v_g) begin
                    // Collector went back to FILL with nothing to send.
`ifdef BSG_COVER_PACKER_TRAILER_EN
                    state_d = StTrail;
`else
                    state_d = StEnd;
`endif
                end
            end
            StEnd: begin
                v_o    = 1'b1;
                last_o = 1'b1;
                data_o = {out_width_p{EndBeatFill}};
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            StTrail: begin
`ifdef BSG_COVER_PACKER_TRAILER_EN
                v_o                               = 1'b1;
                last_o                            = 1'b1;
                data_o[out_width_p-1 -: 16]       = TrailerMagic;
                data_o[CntW-1:0]                  = cnt_q;
                if (ready_i) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Drain bookkeeping: a new host request always wins over a clearing header.
    always_comb begin
        pending_d    = pending_q;
        active_d     = active_q;
        drain_done_o = active_q && (pending_q == '0) && (state_q == StIdle);
        if (drain_done_o) begin
            active_d = 1'b0;
        end
        if (hdr_xfer) begin
            pending_d = pending_q & ~grant_oh_q;
        end
        if (drain_i) begin
            pending_d = '1;
            active_d  = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_oh_q <= '0;
            pending_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
        end
    end

`ifdef BSG_COVER_PACKER_TRAILER_EN
    // Data-beat counter for the trailer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cover_packer.sv
// Self-checking bench for bsg_cover_packer (default parameters).
module tb_bsg_cover_packer;
    import bsg_cover_pkg::*;

    localparam int NUM = 4;
    localparam int W   = 64;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             drain_i;
    logic [NUM-1:0]   drain_o;
    logic [NUM-1:0]   gate_i;
    logic             drain_done_o;
    logic [NUM-1:0]   id_v_i;
    logic [NUM*8-1:0] id_i;
    logic [NUM*16-1:0] els_i;
    logic [NUM*8-1:0] len_i;
    logic [NUM-1:0]   ready_o;
    logic [NUM-1:0]   v_i;
    logic [NUM-1:0]   last_i;
    logic [NUM*W-1:0] data_i;
    logic             v_o;
    logic             last_o;
    logic [W-1:0]     data_o;
    logic             ready_i;

    always #5 clk = ~clk;

    bsg_cover_packer #(
        .num_p      (NUM),
        .out_width_p(W),
        .id_width_p (8),
        .els_width_p(16),
        .len_width_p(8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .drain_i     (drain_i),
        .drain_o     (drain_o),
        .gate_i      (gate_i),
        .drain_done_o(drain_done_o),
        .id_v_i      (id_v_i),
        .id_i        (id_i),
        .els_i       (els_i),
        .len_i       (len_i),
        .ready_o     (ready_o),
        .v_i         (v_i),
        .last_i      (last_i),
        .data_i      (data_i),
        .v_o         (v_o),
        .last_o      (last_o),
        .data_o      (data_o),
        .ready_i     (ready_i)
    );

    typedef struct {
        bit          is_hdr;
        logic [7:0]  id;
        logic [15:0] els;
        logic [7:0]  len;
        logic [63:0] data;
        bit          last;
    } chan_item_t;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          ch;
        logic [7:0]  id;
        logic [15:0] els;
        logic [7:0]  len;
        int          nbeats;
        logic [63:0] exp_hdr;
    } vec_t;

    chan_item_t     cq[NUM][$];
    beat_t          sb[$];
    logic [NUM-1:0] pend_m;
    int             tests = 0;
    int             fails = 0;
    int             done_cnt = 0;
    bit             drain_req = 0;
    bit             bp = 0;
    bit             bubbles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit busy();
        for (int k = 0; k < NUM; k++) begin
            if (cq[k].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Queue a packet on channel ch and its expected output beats on the scoreboard.
    task automatic push_packet(input int ch, input logic [7:0] id, input logic [15:0] els,
                               input logic [7:0] len, input int n, input logic [63:0] exp_hdr);
        chan_item_t it;
        beat_t      b;
        it = '{is_hdr: 1'b1, id: id, els: els, len: len, data: '0, last: 1'b0};
        cq[ch].push_back(it);
        b = '{ch: ch, data: exp_hdr, last: 1'b0};
        sb.push_back(b);
        for (int i = 0; i < n; i++) begin
            it = '{is_hdr: 1'b0, id: '0, els: '0, len: '0,
                   data: {8'hD0, 8'(ch), id, 8'h00, 32'(i)}, last: (i == n - 1)};
            cq[ch].push_back(it);
`ifdef BSG_COVER_PACKER_TRAILER_EN
            b = '{ch: ch, data: it.data, last: 1'b0};
`else
            b = '{ch: ch, data: it.data, last: (i == n - 1)};
`endif
            sb.push_back(b);
        end
`ifdef BSG_COVER_PACKER_TRAILER_EN
        b = '{ch: ch, data: {16'hC0DE, 16'h0000, 32'(n)}, last: 1'b1};
        sb.push_back(b);
`else
        if (n == 0) begin
            b = '{ch: ch, data: '1, last: 1'b1};
            sb.push_back(b);
        end
`endif
    endtask

    // One clock: drive channels, check outputs at negedge, advance channel queues.
    task automatic tick();
        chan_item_t it;
        beat_t      e;
        bit         ok;
        drain_i = drain_req;
        ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < NUM; k++) begin
            id_v_i[k] = 1'b0; v_i[k] = 1'b0; last_i[k] = 1'b0; gate_i[k] = 1'b0;
            id_i[k*8 +: 8] = '0; els_i[k*16 +: 16] = '0; len_i[k*8 +: 8] = '0;
            data_i[k*W +: W] = '0;
            if (cq[k].size() > 0) begin
                gate_i[k] = 1'b1;
                it = cq[k][0];
                if (it.is_hdr) begin
                    id_v_i[k] = 1'b1;
                    id_i[k*8 +: 8] = it.id;
                    els_i[k*16 +: 16] = it.els;
                    len_i[k*8 +: 8] = it.len;
                end else begin
                    v_i[k] = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
                    data_i[k*W +: W] = it.data;
                    last_i[k] = it.last;
                end
            end
        end
        @(negedge clk);
        if (ready_o != '0) begin
            tests++;
            ok = ($countones(ready_o) == 1) && (sb.size() > 0);
            if (ok) ok = ready_o[sb[0].ch];
            if (!ok) begin
                fails++;
                $display("FAIL ready_grant: ready_o=%b expected only channel %0d", ready_o,
                         (sb.size() > 0) ? sb[0].ch : -1);
            end
        end
        chk("drain_o", 64'(drain_o), 64'(pend_m));
        if (v_o && ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_beat: got data %h last %b, expected no beat", data_o, last_o);
            end else begin
                e = sb.pop_front();
                chk("beat_data", data_o, e.data);
                chk("beat_last", 64'(last_o), 64'(e.last));
            end
        end
        if (drain_done_o) begin
            done_cnt++;
            chk("done_after_last", 64'(sb.size()), 64'd0);
        end
        for (int k = 0; k < NUM; k++) begin
            if (ready_o[k] && cq[k].size() > 0) begin
                if (cq[k][0].is_hdr) begin
                    void'(cq[k].pop_front());
                    pend_m[k] = 1'b0;
                end else if (v_i[k]) begin
                    void'(cq[k].pop_front());
                end
            end
        end
        if (drain_i) pend_m = '1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int budget);
        int cyc;
        cyc = 0;
        while ((sb.size() > 0 || busy()) && cyc < budget) begin
            tick();
            cyc++;
        end
        if (sb.size() > 0 || busy()) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d beats still expected, needed 0", sb.size());
            sb.delete();
            for (int k = 0; k < NUM; k++) cq[k].delete();
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        drain_i = 1'b0; drain_req = 1'b0;
        ready_i = 1'b1;
        id_v_i = '0; v_i = '0; last_i = '0; gate_i = '0;
        id_i = '0; els_i = '0; len_i = '0; data_i = '0;
        for (int k = 0; k < NUM; k++) cq[k].delete();
        sb.delete();
        pend_m = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   pk_n[3][2];
        logic [7:0]  pk_id[3][2];
        logic [15:0] pk_els[3][2];
        logic [7:0]  pk_len[3][2];
        int   idx[3];
        int   p;
        int   c;
        bit   found;
        cover_hdr_t h;

        vecs[0] = '{ch: 0, id: 8'h05, els: 16'h0004, len: 8'h02, nbeats: 8,
                    exp_hdr: 64'h0000_0000_0200_0405};
        vecs[1] = '{ch: 1, id: 8'hA3, els: 16'hBEEF, len: 8'h7F, nbeats: 3,
                    exp_hdr: 64'h0000_0000_7FBE_EFA3};
        vecs[2] = '{ch: 3, id: 8'hFF, els: 16'hFFFF, len: 8'hFF, nbeats: 1,
                    exp_hdr: 64'h0000_0000_FFFF_FFFF};
        vecs[3] = '{ch: 2, id: 8'h00, els: 16'h0000, len: 8'h00, nbeats: 0,
                    exp_hdr: 64'h0000_0000_0000_0000};
        vecs[4] = '{ch: 2, id: 8'h12, els: 16'h0000, len: 8'h01, nbeats: 2,
                    exp_hdr: 64'h0000_0000_0100_0012};

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_last_o", 64'(last_o), 64'd0);
        chk("rst_data_o", data_o, 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd0);
        chk("rst_drain_o", 64'(drain_o), 64'd0);
        chk("rst_done", 64'(drain_done_o), 64'd0);
        @(posedge clk);
        #1;

        // Single-channel packets from the vector table.
        for (int i = 0; i < 5; i++) begin
            push_packet(vecs[i].ch, vecs[i].id, vecs[i].els, vecs[i].len, vecs[i].nbeats,
                        vecs[i].exp_hdr);
            run_until(200);
        end

        // Tie between channels 1 and 3 from rr=0, then 0 vs 2 after channel 3 wraps.
        do_reset();
        push_packet(1, 8'h11, 16'h0101, 8'h01, 3, 64'h0000_0000_0101_0111);
        push_packet(3, 8'h33, 16'h0303, 8'h03, 2, 64'h0000_0000_0303_0333);
        run_until(200);
        push_packet(0, 8'h40, 16'h0004, 8'h04, 2, 64'h0000_0000_0400_0440);
        push_packet(2, 8'h42, 16'h0002, 8'h02, 1, 64'h0000_0000_0200_0242);
        run_until(200);

        // Host drain over all four channels.
        do_reset();
        done_cnt = 0;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        chk("drain_armed", 64'(drain_o), 64'hF);
        for (int k = 0; k < NUM; k++) begin
            push_packet(k, 8'(8'h80 + k), 16'(k), 8'h01, k + 1, {32'h0, 8'h01, 16'(k), 8'(8'h80 + k)});
        end
        run_until(400);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("drain_o_final", 64'(drain_o), 64'd0);

        // Random backpressure and valid bubbles over channels 0..2.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                pk_n[k][j]   = $urandom_range(1, 5);
                pk_id[k][j]  = 8'($urandom);
                pk_els[k][j] = 16'($urandom);
                pk_len[k][j] = 8'($urandom);
            end
            idx[k] = 0;
        end
        p = 0;
        for (int n = 0; n < 6; n++) begin
            found = 1'b0;
            for (int i = 0; i < NUM; i++) begin
                c = (p + i) % NUM;
                if (!found && c < 3 && idx[c] < 2) begin
                    found = 1'b1;
                    h.len = pk_len[c][idx[c]];
                    h.els = pk_els[c][idx[c]];
                    h.id  = pk_id[c][idx[c]];
                    push_packet(c, h.id, h.els, h.len, pk_n[c][idx[c]], 64'(h));
                    idx[c]++;
                    p = (c + 1) % NUM;
                end
            end
        end
        bp = 1'b1;
        bubbles = 1'b1;
        run_until(2000);
        bp = 1'b0;
        bubbles = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
